servant_uart_rx: RTL and testbench

UART receiver that consumes the serial `q` line driven by the servant SoC and turns it into bytes. It sits directly downstream of the SoC's UART output. In simulation it replaces the behavioural UART decoder; on the FPGA it feeds a byte sink such as a logger or loopback. Output is 8N1, LSB first, with a 4-entry byte FIFO and a valid/ready handshake.

---
 rtl/servant_uart_rx.sv | 205 ++++++++++++++++++++
 tb/tb_servant_uart_rx.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/servant_uart_rx.sv
// 8N1 UART receiver with a small byte FIFO. A byte appears on o_rdt/o_valid the cycle
// after its stop-bit mid-sample. The FIFO drops a byte when full; a pop in the same cycle makes room.

module servant_uart_fifo #(
    parameter int DEPTH_LOG2 = 2,
    parameter int WIDTH      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_dat,
    output logic             wr_rdy,
    output logic             rd_vld,
    output logic [WIDTH-1:0] rd_dat,
    input  logic             rd_rdy
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [WIDTH-1:0]      mem_d [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  push, pop;

    // count never exceeds DEPTH, so its top bit alone means "full"
    assign rd_vld = (count_q != '0);
    assign pop    = rd_vld & rd_rdy;
    assign wr_rdy = ~count_q[DEPTH_LOG2] | pop;
    assign push   = wr_vld & wr_rdy;
    assign rd_dat = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + (DEPTH_LOG2 + 1)'(push) - (DEPTH_LOG2 + 1)'(pop);
        if (push) begin
            mem_d[wr_ptr_q] = wr_dat;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

module servant_uart_rx #(
    parameter int CLKS_PER_BIT    = 280,
    parameter int FIFO_DEPTH_LOG2 = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx,
    output logic [7:0] o_rdt,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_busy,
    output logic       o_frame_err,
    output logic       o_overrun
);
    localparam int            CW      = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shreg_q, shreg_d;
    logic        rx_meta_q, rx_meta_d;
    logic        rx_s_q, rx_s_d;
    logic        busy_q, busy_d;
    logic        frame_err_q, frame_err_d;
    logic        overrun_q, overrun_d;
    logic        push_vld;
    logic        push_rdy;

    always_comb begin
        rx_meta_d   = i_rx;
        rx_s_d      = rx_meta_q;
        state_d     = state_q;
        cnt_d       = cnt_q + 1'b1;
        idx_d       = idx_q;
        shreg_d     = shreg_q;
        push_vld    = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rx_s_q) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rx_s_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shreg_d = {rx_s_q, shreg_q[7:1]};
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        push_vld = 1'b1;
                        state_d  = S_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                // a line held low must go high before a new start bit is accepted
                cnt_d = '0;
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
        busy_d    = (state_d != S_IDLE);
        overrun_d = push_vld & ~push_rdy;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shreg_q     <= '0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rx_meta_q   <= rx_meta_d;
            rx_s_q      <= rx_s_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shreg_q     <= shreg_d;
            busy_q      <= busy_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    servant_uart_fifo #(
        .DEPTH_LOG2(FIFO_DEPTH_LOG2),
        .WIDTH     (8)
    ) u_fifo (
        .clk   (i_clk),
        .rst   (i_rst),
        .wr_vld(push_vld),
        .wr_dat(shreg_q),
        .wr_rdy(push_rdy),
        .rd_vld(o_valid),
        .rd_dat(o_rdt),
        .rd_rdy(i_ready)
    );

    assign o_busy      = busy_q;
    assign o_frame_err = frame_err_q;
    assign o_overrun   = overrun_q;
endmodule

// File: tb/tb_servant_uart_rx.sv
// Bench for servant_uart_rx: serial frames driven at (or near) the bit rate, bytes collected
// by a negedge monitor and compared against queues of what was sent.
module tb_servant_uart_rx;
    localparam int C       = 16;
    localparam int H       = C / 2;
    localparam int DEPTH   = 4;
    // observed edge of the first o_valid, relative to the edge that first samples the start bit
    localparam int LAT_MIN = H + 9 * C + 2;
    localparam int LAT_MAX = H + 9 * C + 4;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       rx    = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] o_rdt;
    logic       o_valid, o_busy, o_frame_err, o_overrun;

    servant_uart_rx #(.CLKS_PER_BIT(C), .FIFO_DEPTH_LOG2(2)) dut (
        .i_clk(clk), .i_rst(rst), .i_rx(rx), .o_rdt(o_rdt), .o_valid(o_valid),
        .i_ready(ready), .o_busy(o_busy), .o_frame_err(o_frame_err), .o_overrun(o_overrun)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    logic [7:0] q_rx[$];
    int         ferr_cnt, ovr_cnt, valid_hi, valid_rises, stab_err, first_rise;
    int         last_t0, lat_meas;
    logic       prev_valid = 1'b0;
    logic       prev_hold  = 1'b0;
    logic [7:0] prev_rdt   = 8'h00;

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // o_valid & i_ready seen at the negedge is exactly the pop at the next posedge
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (o_valid && ready) q_rx.push_back(o_rdt);
            if (o_frame_err) ferr_cnt++;
            if (o_overrun) ovr_cnt++;
            if (o_valid) valid_hi++;
            if (o_valid && !prev_valid) begin
                valid_rises++;
                if (first_rise < 0) first_rise = cyc;
            end
            if (prev_hold && (!o_valid || o_rdt !== prev_rdt)) stab_err++;
        end
        prev_hold  = o_valid && !ready;
        prev_valid = o_valid;
        prev_rdt   = o_rdt;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_mon();
        q_rx.delete();
        ferr_cnt = 0; ovr_cnt = 0; valid_hi = 0; valid_rises = 0; stab_err = 0; first_rise = -1;
    endtask

    // per_x100: bit period in percent of C, so 97..103 models baud error
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int per_x100);
        int el;
        int bnd;
        el      = 0;
        last_t0 = cyc + 1;
        for (int k = 0; k < 10; k++) begin
            rx  = (k == 0) ? 1'b0 : (k == 9) ? stop_bit : b[k-1];
            bnd = ((k + 1) * C * per_x100 + 50) / 100;
            while (el < bnd) begin
                tick(1);
                el++;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; rx = 1'b1; ready = 1'b0;
        tick(3);
        n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", o_valid); end
        n_tests++; if (o_rdt !== 8'h00) begin n_fail++; $display("FAIL reset_rdt: got %h want 00", o_rdt); end
        n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", o_busy); end
        n_tests++; if (o_frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: got %b want 0", o_frame_err); end
        n_tests++; if (o_overrun !== 1'b0) begin n_fail++; $display("FAIL reset_ovr: got %b want 0", o_overrun); end
        rst = 1'b0;
        tick(2);
    endtask

    task automatic test_single_byte();
        logic [7:0] got;
        ready = 1'b1;
        clear_mon();
        send_frame(8'h48, 1'b1, 100);
        tick(C);
        lat_meas = first_rise - last_t0;
        got = (q_rx.size() > 0) ? q_rx[0] : 8'hxx;
        n_tests++; if (q_rx.size() != 1) begin n_fail++; $display("FAIL single_count: got %0d want 1", q_rx.size()); end
        n_tests++; if (got !== 8'h48) begin n_fail++; $display("FAIL single_data: got %h want 48", got); end
        n_tests++; if (lat_meas < LAT_MIN || lat_meas > LAT_MAX) begin
            n_fail++; $display("FAIL single_latency: got %0d want %0d..%0d", lat_meas, LAT_MIN, LAT_MAX); end
        n_tests++; if (valid_hi != 1) begin n_fail++; $display("FAIL single_valid_width: got %0d want 1", valid_hi); end
        n_tests++; if (ferr_cnt != 0 || ovr_cnt != 0) begin
            n_fail++; $display("FAIL single_flags: got ferr=%0d ovr=%0d want 0 0", ferr_cnt, ovr_cnt); end
        n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL single_busy: got %b want 0", o_busy); end
        if (lat_meas < LAT_MIN || lat_meas > LAT_MAX) lat_meas = LAT_MIN;
    endtask

    task automatic test_back_to_back();
        logic [7:0] sent[$];
        logic [7:0] exp_q[$];
        logic [7:0] got;
        int         exp_ovr;
        sent = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};
        exp_q.delete();
        for (int i = 0; i < sent.size() && i < DEPTH; i++) exp_q.push_back(sent[i]);
        exp_ovr = sent.size() - exp_q.size();
        ready = 1'b0;
        clear_mon();
        foreach (sent[i]) send_frame(sent[i], 1'b1, 100);
        tick(C);
        n_tests++; if (o_valid !== 1'b1 || o_rdt !== exp_q[0]) begin
            n_fail++; $display("FAIL b2b_head: got valid=%b rdt=%h want 1 %h", o_valid, o_rdt, exp_q[0]); end
        n_tests++; if (ovr_cnt != exp_ovr) begin n_fail++; $display("FAIL b2b_overrun: got %0d want %0d", ovr_cnt, exp_ovr); end
        n_tests++; if (ferr_cnt != 0) begin n_fail++; $display("FAIL b2b_ferr: got %0d want 0", ferr_cnt); end
        ready = 1'b1;
        tick(8);
        ready = 1'b0;
        n_tests++; if (q_rx.size() != exp_q.size()) begin
            n_fail++; $display("FAIL b2b_count: got %0d want %0d", q_rx.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < q_rx.size()) ? q_rx[i] : 8'hxx;
            n_tests++; if (got !== exp_q[i]) begin n_fail++; $display("FAIL b2b_byte%0d: got %h want %h", i, got, exp_q[i]); end
        end
        n_tests++; if (stab_err != 0) begin n_fail++; $display("FAIL b2b_stable: got %0d changes want 0", stab_err); end
    endtask

    task automatic test_frame_error();
        logic [7:0] got;
        ready = 1'b1;
        clear_mon();
        send_frame(8'hA5, 1'b0, 100);
        tick(40);
        n_tests++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL ferr_break_busy: got %b want 1", o_busy); end
        n_tests++; if (ferr_cnt != 1) begin n_fail++; $display("FAIL ferr_pulse: got %0d want 1", ferr_cnt); end
        n_tests++; if (q_rx.size() != 0) begin n_fail++; $display("FAIL ferr_nopush: got %0d want 0", q_rx.size()); end
        rx = 1'b1;
        tick(4);
        n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL ferr_idle: got %b want 0", o_busy); end
        send_frame(8'h3C, 1'b1, 100);
        tick(C);
        got = (q_rx.size() > 0) ? q_rx[0] : 8'hxx;
        n_tests++; if (q_rx.size() != 1 || got !== 8'h3C) begin
            n_fail++; $display("FAIL ferr_next: got n=%0d %h want 1 3c", q_rx.size(), got); end
        n_tests++; if (ferr_cnt != 1 || ovr_cnt != 0) begin
            n_fail++; $display("FAIL ferr_flags: got ferr=%0d ovr=%0d want 1 0", ferr_cnt, ovr_cnt); end
    endtask

    task automatic test_glitch();
        ready = 1'b1;
        clear_mon();
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        n_tests++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL glitch_start: got %b want 1", o_busy); end
        tick(C);
        n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL glitch_idle: got %b want 0", o_busy); end
        n_tests++; if (valid_rises != 0 || ferr_cnt != 0 || ovr_cnt != 0) begin
            n_fail++; $display("FAIL glitch_quiet: got push=%0d ferr=%0d ovr=%0d want 0 0 0", valid_rises, ferr_cnt, ovr_cnt); end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] got;
        ready = 1'b1;
        clear_mon();
        rx = 1'b0;
        tick(C);
        rx = 1'b1;
        tick(3 * C + H);
        rst = 1'b1;
        tick(2);
        n_tests++; if ({o_valid, o_busy, o_frame_err, o_overrun} !== 4'b0000 || o_rdt !== 8'h00) begin
            n_fail++; $display("FAIL rstmid_outputs: got v=%b b=%b f=%b o=%b rdt=%h want all 0",
                               o_valid, o_busy, o_frame_err, o_overrun, o_rdt); end
        rst = 1'b0;
        tick((C - H) + 5 * C);
        send_frame(8'h01, 1'b1, 100);
        tick(C);
        got = (q_rx.size() > 0) ? q_rx[0] : 8'hxx;
        n_tests++; if (q_rx.size() != 1 || got !== 8'h01) begin
            n_fail++; $display("FAIL rstmid_data: got n=%0d %h want 1 01", q_rx.size(), got); end
        n_tests++; if (ferr_cnt != 0 || ovr_cnt != 0) begin
            n_fail++; $display("FAIL rstmid_flags: got ferr=%0d ovr=%0d want 0 0", ferr_cnt, ovr_cnt); end
    endtask

    task automatic test_full_simul_pop();
        logic [7:0] b[5];
        logic [7:0] got;
        int         t0x;
        for (int i = 0; i < 5; i++) b[i] = 8'($urandom);
        ready = 1'b0;
        clear_mon();
        for (int i = 0; i < DEPTH; i++) send_frame(b[i], 1'b1, 100);
        tick(C);
        t0x = cyc + 1;
        fork
            send_frame(b[4], 1'b1, 100);
            begin
                while (cyc < t0x + lat_meas - 1) tick(1);
                ready = 1'b1;
                tick(1);
                ready = 1'b0;
            end
        join
        tick(C);
        n_tests++; if (ovr_cnt != 0) begin n_fail++; $display("FAIL full_pop_overrun: got %0d want 0", ovr_cnt); end
        n_tests++; if (q_rx.size() != 1 || o_valid !== 1'b1) begin
            n_fail++; $display("FAIL full_pop_state: got popped=%0d valid=%b want 1 1", q_rx.size(), o_valid); end
        ready = 1'b1;
        tick(8);
        ready = 1'b0;
        n_tests++; if (q_rx.size() != 5) begin n_fail++; $display("FAIL full_pop_count: got %0d want 5", q_rx.size()); end
        for (int i = 0; i < 5; i++) begin
            got = (i < q_rx.size()) ? q_rx[i] : 8'hxx;
            n_tests++; if (got !== b[i]) begin n_fail++; $display("FAIL full_pop_byte%0d: got %h want %h", i, got, b[i]); end
        end
    endtask

    task automatic test_random();
        logic [7:0] sent[$];
        logic [7:0] b;
        logic [7:0] got;
        ready = 1'b1;
        clear_mon();
        sent.delete();
        for (int i = 0; i < 12; i++) begin
            b = 8'($urandom);
            sent.push_back(b);
            send_frame(b, 1'b1, 97 + int'($urandom_range(0, 6)));
            tick(int'($urandom_range(0, 20)));
        end
        tick(2 * C);
        n_tests++; if (q_rx.size() != sent.size()) begin
            n_fail++; $display("FAIL rand_count: got %0d want %0d", q_rx.size(), sent.size()); end
        for (int i = 0; i < sent.size(); i++) begin
            got = (i < q_rx.size()) ? q_rx[i] : 8'hxx;
            n_tests++; if (got !== sent[i]) begin n_fail++; $display("FAIL rand_byte%0d: got %h want %h", i, got, sent[i]); end
        end
        n_tests++; if (ferr_cnt != 0 || ovr_cnt != 0) begin
            n_fail++; $display("FAIL rand_flags: got ferr=%0d ovr=%0d want 0 0", ferr_cnt, ovr_cnt); end
    endtask

    initial begin
        lat_meas = LAT_MIN;
        clear_mon();
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_frame_error();
        test_glitch();
        test_reset_mid_frame();
        test_full_simul_pop();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
